rx_sampler: RTL and testbench

RX_SAMPLER -- requirements
Module: rx_sampler

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sampler_if.sv | 26 ++
 rtl/rx_sync.sv | 22 ++
 rtl/rx_sampler.sv | 152 +++++++++++++++
 tb/tb_rx_sampler.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and receive-state encoding for the UART receive path.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_HUNT      = 3'd0,
        ST_START_CHK = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

endpackage

// File: rtl/rx_sampler_if.sv
// Control/status bundle between the receive control FSM (master) and rx_sampler (slave).
interface rx_sampler_if;
    import uart_pkg::*;

    logic                 start;
    logic                 shift;
    logic                 parity_load;
    logic                 chk_stop;
    logic                 strt_bit;
    logic                 data_valid;
    logic                 parity_error;
    logic                 stop_error;
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;

    modport master (
        output start, shift, parity_load, chk_stop,
        input  strt_bit, data_valid, parity_error, stop_error, rx_done, rx_data
    );

    modport slave (
        input  start, shift, parity_load, chk_stop,
        output strt_bit, data_valid, parity_error, stop_error, rx_done, rx_data
    );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments keep these as two distinct flop stages; blocking would collapse them into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_sampler.sv
// Oversampling UART receive datapath: start-bit qualification, mid-bit sampling,
// parity/stop checking and a held result until the control FSM releases shift.
module rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         baud_tick,
    input  logic         rx,
    rx_sampler_if.slave  bus
);

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    state_t               state, state_next;
    logic                 rxs, rxs_q, rxs_fall;
    logic [TICK_W-1:0]    tick_cnt;
    logic [2:0]           bit_cnt;
    logic                 tick_clr, tick_inc, start_ok, bit_take, par_take, stop_take;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 strt_bit_q, data_valid_q, parity_error_q, stop_error_q, rx_done_q;
    logic                 unused_parity_load;

    rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    // A line already low when hunting starts is a break, not a start bit.
    assign rxs_fall = rxs_q & ~rxs;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_HUNT;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave a latch behind.
        state_next = state;
        tick_clr   = 1'b0;
        tick_inc   = 1'b0;
        start_ok   = 1'b0;
        bit_take   = 1'b0;
        par_take   = 1'b0;
        stop_take  = 1'b0;
        case (state)
            ST_HUNT: begin
                if (bus.start && rxs_fall) begin
                    tick_clr   = 1'b1;
                    state_next = ST_START_CHK;
                end
            end
            ST_START_CHK: begin
                if (baud_tick) begin
                    if (tick_cnt != TICK_MID) begin
                        tick_inc = 1'b1;
                    end else begin
                        tick_clr = 1'b1;
                        if (!rxs) begin
                            start_ok   = 1'b1;
                            state_next = ST_DATA;
                        end else begin
                            state_next = ST_HUNT;
                        end
                    end
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                if (!bus.shift) begin
                    state_next = ST_HUNT;
                end else if (baud_tick) begin
                    if (tick_cnt != TICK_LAST) begin
                        tick_inc = 1'b1;
                    end else begin
                        tick_clr = 1'b1;
                        if (state == ST_DATA) begin
                            bit_take = 1'b1;
                            if (bit_cnt == BIT_LAST) state_next = ST_PARITY;
                        end else if (state == ST_PARITY) begin
                            par_take   = 1'b1;
                            state_next = ST_STOP;
                        end else begin
                            stop_take  = 1'b1;
                            state_next = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.shift) state_next = ST_HUNT;
            end
            default: state_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxs_q          <= 1'b1;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            rx_data_q      <= '0;
            strt_bit_q     <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            rx_done_q      <= 1'b0;
        end else begin
            rxs_q <= rxs;

            if (tick_clr)      tick_cnt <= '0;
            else if (tick_inc) tick_cnt <= tick_cnt + TICK_W'(1);

            if (start_ok)      bit_cnt <= '0;
            else if (bit_take) bit_cnt <= bit_cnt + 3'd1;

            // LSB arrives first, so each sample enters at the MSB and shifts right.
            if (bit_take) rx_data_q <= {rxs, rx_data_q[DATA_BITS-1:1]};

            if (start_ok) begin
                parity_error_q <= 1'b0;
                stop_error_q   <= 1'b0;
            end
            if (par_take)  parity_error_q <= (^rx_data_q) ^ rxs ^ PARITY_ODD;
            if (stop_take) stop_error_q   <= ~rxs;

            if (stop_take)                          data_valid_q <= 1'b1;
            else if (state == ST_HOLD && !bus.shift) data_valid_q <= 1'b0;

            strt_bit_q <= start_ok;
            rx_done_q  <= bus.chk_stop & ~stop_error_q;
        end
    end

    // Parity checking is self-timed here; the control FSM's parity strobe has no effect.
    assign unused_parity_load = bus.parity_load;

    assign bus.strt_bit     = strt_bit_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.stop_error   = stop_error_q;
    assign bus.rx_done      = rx_done_q;
    assign bus.rx_data      = rx_data_q;

endmodule

// File: tb/tb_rx_sampler.sv
// Scenario bench for rx_sampler: frames are serialised with 16x oversampling, results
// scoreboarded on each data_valid rise, and strt_bit/rx_done pulses counted.
module tb_rx_sampler;

    localparam int OVS    = 16;
    localparam bit P_ODD  = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    logic clk = 1'b0;
    logic reset, baud_tick, rx;
    rx_sampler_if bus ();

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         strt_cnt = 0;
    int         done_cnt = 0;
    logic       dv_q = 1'b0;
    logic       strt_q = 1'b0;
    logic [7:0] model_rx = 8'h00;

    rx_sampler #(.OVERSAMPLE(OVS), .PARITY_ODD(P_ODD)) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .rx        (rx),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Monitor: pulse counting and scoreboard pop on every data_valid rise.
    always @(negedge clk) begin
        if (reset) begin
            dv_q   = 1'b0;
            strt_q = 1'b0;
        end else begin
            if (bus.strt_bit) begin
                strt_cnt++;
                checks++;
                if (strt_q) begin
                    failures++;
                    $display("FAIL strt_bit_width: got two-cycle pulse, expected single cycle");
                end
            end
            if (bus.rx_done) done_cnt++;
            if (bus.data_valid && !dv_q) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_data_valid: got rx_data=%02h with no frame expected", bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rx_data !== e.data || bus.parity_error !== e.perr || bus.stop_error !== e.serr) begin
                        failures++;
                        $display("FAIL frame_result: got data=%02h perr=%b serr=%b expected data=%02h perr=%b serr=%b",
                                 bus.rx_data, bus.parity_error, bus.stop_error, e.data, e.perr, e.serr);
                    end
                end
            end
            dv_q   = bus.data_valid;
            strt_q = bus.strt_bit;
        end
    end

    task automatic baud(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) baud_tick = 1'b1;
            @(negedge clk) baud_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit, input bit stall);
        exp_t e;
        int   s0, d0, exp_done;
        e.data = d;
        e.perr = (^d) ^ par_bit ^ P_ODD;
        e.serr = ~stop_bit;
        exp_q.push_back(e);
        exp_done = (e.perr || e.serr) ? 0 : 1;
        s0 = strt_cnt;
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.shift = 1'b1;
        rx        = 1'b0;
        baud(4);
        if (stall) begin
            repeat (60) @(negedge clk);
            checks++;
            if (strt_cnt != s0) begin
                failures++;
                $display("FAIL tick_gating: got strt pulses=%0d expected 0 without baud_tick", strt_cnt - s0);
            end
        end
        baud(OVS - 4);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            baud(OVS);
        end
        rx = par_bit;
        baud(OVS);
        rx = stop_bit;
        baud(OVS);
        rx = 1'b1;
        checks++;
        if (bus.data_valid !== 1'b1) begin
            failures++;
            $display("FAIL data_valid_set %02h: got %b expected 1", d, bus.data_valid);
        end
        // The control FSM only issues the stop check for frames with good parity.
        if (!e.perr) begin
            @(negedge clk) bus.chk_stop = 1'b1;
            @(negedge clk) bus.chk_stop = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.data_valid !== 1'b1 || bus.rx_data !== d) begin
            failures++;
            $display("FAIL hold_stable %02h: got dv=%b data=%02h expected dv=1 data=%02h", d, bus.data_valid, bus.rx_data, d);
        end
        bus.shift = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.data_valid !== 1'b0) begin
            failures++;
            $display("FAIL data_valid_drop %02h: got %b expected 0", d, bus.data_valid);
        end
        checks++;
        if (strt_cnt - s0 != 1) begin
            failures++;
            $display("FAIL strt_count %02h: got %0d expected 1", d, strt_cnt - s0);
        end
        checks++;
        if (done_cnt - d0 != exp_done) begin
            failures++;
            $display("FAIL rx_done_count %02h: got %0d expected %0d", d, done_cnt - d0, exp_done);
        end
        model_rx = d;
        baud(2);
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        rx              = 1'b1;
        baud_tick       = 1'b0;
        bus.start       = 1'b0;
        bus.shift       = 1'b0;
        bus.parity_load = 1'b0;
        bus.chk_stop    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.strt_bit, bus.data_valid, bus.parity_error, bus.stop_error, bus.rx_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.strt_bit, bus.data_valid, bus.parity_error, bus.stop_error, bus.rx_done});
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rx_data: got %02h expected 00", bus.rx_data);
        end
        reset = 1'b0;
        baud(2);
    endtask

    task automatic test_good_frame();
        // parity_load pulses mid-frame must be ignored.
        fork
            begin
                repeat (300) @(negedge clk);
                bus.parity_load = 1'b1;
                @(negedge clk) bus.parity_load = 1'b0;
            end
        join_none
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_parity_error();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_stop_error();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        int s0;
        s0 = strt_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.shift = 1'b1;
        rx        = 1'b0;
        baud(5);
        rx = 1'b1;
        baud(20);
        checks++;
        if (strt_cnt != s0 || bus.data_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: got strt=%0d dv=%b expected strt=0 dv=0", strt_cnt - s0, bus.data_valid);
        end
        bus.start = 1'b0;
        bus.shift = 1'b0;
        baud(2);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_break();
        int s0;
        s0 = strt_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        rx        = 1'b0;
        baud(4);
        bus.start = 1'b1;
        bus.shift = 1'b1;
        baud(40);
        checks++;
        if (strt_cnt != s0) begin
            failures++;
            $display("FAIL break_no_start: got strt=%0d expected 0", strt_cnt - s0);
        end
        rx        = 1'b1;
        bus.start = 1'b0;
        bus.shift = 1'b0;
        baud(2);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h55;
        @(negedge clk);
        bus.start = 1'b1;
        bus.shift = 1'b1;
        rx        = 1'b0;
        baud(OVS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            baud(OVS);
        end
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rx_data !== 8'h00 || bus.data_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_reset: got data=%02h dv=%b expected data=00 dv=0", bus.rx_data, bus.data_valid);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.shift = 1'b0;
        model_rx  = 8'h00;
        baud(4);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        logic [7:0] d, exp_part;
        int         s0;
        d        = 8'h6B;
        exp_part = model_rx;
        for (int i = 0; i < 3; i++) exp_part = {d[i], exp_part[7:1]};
        s0 = strt_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.shift = 1'b1;
        rx        = 1'b0;
        baud(OVS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            baud(OVS);
        end
        bus.shift = 1'b0;
        bus.start = 1'b0;
        rx        = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rx_data !== exp_part) begin
            failures++;
            $display("FAIL abort_partial: got %02h expected %02h", bus.rx_data, exp_part);
        end
        baud(OVS * 8);
        checks++;
        if (bus.rx_data !== exp_part || bus.data_valid !== 1'b0 || strt_cnt - s0 != 1) begin
            failures++;
            $display("FAIL abort_idle: got data=%02h dv=%b strt=%0d expected data=%02h dv=0 strt=1",
                     bus.rx_data, bus.data_valid, strt_cnt - s0, exp_part);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d frames outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
